// File: rtl/spi_master_burst.sv
// Burst SPI master: internal SCK divider, per-burst word count, automatic
// slave select held across the whole burst, valid/ready TX and strobed RX.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start_i; SCK follows live cpol_i
// SS_SETUP | select asserted, one SCK half-period of setup before data
// LOAD     | tx_ready_o high; waits (SCK idle) for the next TX word
// LEAD     | first half of a bit; leading SCK edge at the end
// TRAIL    | second half of a bit; trailing SCK edge at the end
// SS_HOLD  | select held one half-period after the last edge, then irq
module spi_master_burst #(
  parameter int DATA_W = 8,
  parameter int SS_N   = 4,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 8,
  // One extra bit so an out-of-range slave index can be requested; such a
  // transfer runs with every select left high.
  parameter int SEL_W  = $clog2(SS_N) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [SEL_W-1:0]  ss_sel_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              dord_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              irq_o,
  input  logic              ack_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              mosi_en_o,
  input  logic              miso_i,
  output logic [SS_N-1:0]   ss_n_o
);

  localparam int BC_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, SS_SETUP, LOAD, LEAD, TRAIL, SS_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d, word_q, word_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, dord_q, dord_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, mosi_q, mosi_d, sclk_q, sclk_d;
  logic              irq_q, irq_d;
  logic [SS_N-1:0]   ss_n_q, ss_n_d;

  logic              tick, last_bit;
  logic [DATA_W-1:0] rx_shifted, tx_shifted;
  logic              tx_first_bit, tx_cur_bit, tx_next_bit;

  // Divider tick, bit-order aware shift helpers.
  always_comb begin
    tick         = (cnt_q == div_q);
    last_bit     = (bit_q == BC_W'(DATA_W - 1));
    rx_shifted   = dord_q ? {miso_i, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso_i};
    tx_shifted   = dord_q ? {1'b0, tx_sh_q[DATA_W-1:1]} : {tx_sh_q[DATA_W-2:0], 1'b0};
    tx_first_bit = dord_q ? tx_data_i[0] : tx_data_i[DATA_W-1];
    tx_cur_bit   = dord_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    tx_next_bit  = dord_q ? tx_sh_q[1] : tx_sh_q[DATA_W-2];
  end

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    len_d      = len_q;
    word_d     = word_q;
    bit_d      = bit_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    dord_d     = dord_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    irq_d      = irq_q & ~ack_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          div_d   = div_i;
          len_d   = len_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          dord_d  = dord_i;
          word_d  = '0;
          mosi_d  = 1'b0;
          sclk_d  = 1'b0;
          ss_n_d  = (int'(ss_sel_i) < SS_N) ? ~(SS_N'(1) << ss_sel_i) : '1;
          state_d = SS_SETUP;
        end
      end
      SS_SETUP: begin
        if (tick) state_d = LOAD;
      end
      LOAD: begin
        if (tx_valid_i) begin
          tx_sh_d = tx_data_i;
          rx_sh_d = '0;
          bit_d   = '0;
          // cpha=0 drives the first bit before the first edge.
          if (!cpha_q) mosi_d = tx_first_bit;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          sclk_d = 1'b1;
          if (!cpha_q) begin
            rx_sh_d = rx_shifted;
          end else begin
            mosi_d  = tx_cur_bit;
            tx_sh_d = tx_shifted;
          end
          state_d = TRAIL;
        end
      end
      TRAIL: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (cpha_q) rx_sh_d = rx_shifted;
          if (last_bit) begin
            // For cpha=1 the final sample lands on this very edge.
            rx_data_d  = cpha_q ? rx_shifted : rx_sh_q;
            rx_valid_d = 1'b1;
            if (word_q < len_q) begin
              word_d  = word_q + LEN_W'(1);
              state_d = LOAD;
            end else begin
              state_d = SS_HOLD;
            end
          end else begin
            if (!cpha_q) begin
              mosi_d  = tx_next_bit;
              tx_sh_d = tx_shifted;
            end
            bit_d   = bit_q + BC_W'(1);
            state_d = LEAD;
          end
        end
      end
      SS_HOLD: begin
        if (tick) begin
          ss_n_d  = '1;
          irq_d   = 1'b1;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The divider restarts on every state entry so each phase is a full T.
    if (state_q == IDLE || state_d != state_q || tick) cnt_d = '0;
    else                                                 cnt_d = cnt_q + DIV_W'(1);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      dord_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      dord_q     <= dord_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      irq_q      <= irq_d;
    end
  end

  // Pin-level outputs; SCK polarity follows the live input only while idle.
  always_comb begin
    busy_o     = (state_q != IDLE);
    mosi_en_o  = busy_o;
    tx_ready_o = (state_q == LOAD);
    sclk_o     = sclk_q ^ ((state_q == IDLE) ? cpol_i : cpol_q);
    mosi_o     = mosi_q;
    ss_n_o     = ss_n_q;
    rx_data_o  = rx_data_q;
    rx_valid_o = rx_valid_q;
    irq_o      = irq_q;
  end

endmodule

// File: tb/tb_spi_master_burst.sv
// Bench for spi_master_burst: a timeline model derives every output cycle by
// cycle from the burst timing rules; a negedge process compares against it.
module tb_spi_master_burst;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1, start_i = 1'b0, cpol_i = 1'b0, cpha_i = 1'b0, dord_i = 1'b0;
  logic [2:0] ss_sel_i = '0;
  logic [7:0] len_i = '0, div_i = '0, tx_data_i = '0, rx_data_o;
  logic       tx_valid_i = 1'b0, tx_ready_o, rx_valid_o, busy_o, irq_o, ack_i = 1'b0;
  logic       sclk_o, mosi_o, mosi_en_o, miso_i = 1'b0;
  logic [3:0] ss_n_o;

  spi_master_burst dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ss_sel_i(ss_sel_i),
    .len_i(len_i), .div_i(div_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .dord_i(dord_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o), .irq_o(irq_o),
    .ack_i(ack_i), .sclk_o(sclk_o), .mosi_o(mosi_o), .mosi_en_o(mosi_en_o),
    .miso_i(miso_i), .ss_n_o(ss_n_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // expected outputs for the current cycle
  logic       chk_en = 1'b0;
  logic       exp_busy, exp_sclk, exp_mosi, exp_ready, exp_rxv, exp_irq;
  logic [3:0] exp_ss;
  logic [7:0] exp_rxd;

  int  rel = 0, abort_rel = -1, extra_start = -1;
  bit  aborted = 0, irq_set = 0;
  logic [7:0] tx_w [4];
  logic [7:0] rx_w [4];
  int         stall_w [4];

  // observation counters
  int         edges, rxv_cnt, irq_rises, irq_rise_rel;
  logic [7:0] cap;
  logic [3:0] ss_and;
  logic       irq_prev = 1'b0, sclk_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at rel %0d: got %0h want %0h", name, rel, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy_o, exp_busy);
      chk("mosi_en", mosi_en_o, exp_busy);
      chk("ss_n", ss_n_o, exp_ss);
      chk("sclk", sclk_o, exp_sclk);
      chk("mosi", mosi_o, exp_mosi);
      chk("tx_ready", tx_ready_o, exp_ready);
      chk("rx_valid", rx_valid_o, exp_rxv);
      chk("rx_data", rx_data_o, exp_rxd);
      chk("irq", irq_o, exp_irq);
    end
  end

  // Event monitor feeding the hand-computed literal checks.
  always @(negedge clk) begin
    if (irq_o && !irq_prev) begin irq_rises++; irq_rise_rel = rel; end
    if (busy_o && sclk_o && !sclk_prev) begin edges++; cap = {cap[6:0], mosi_o}; end
    if (rx_valid_o) rxv_cnt++;
    ss_and = ss_and & ss_n_o;
    irq_prev  = irq_o;
    sclk_prev = sclk_o;
  end

  task automatic clr_mon();
    edges = 0; rxv_cnt = 0; irq_rises = 0; irq_rise_rel = -1; cap = '0; ss_and = 4'hF;
  endtask

  function automatic logic txbit(input int k, input int b, input bit ord);
    logic [7:0] w;
    w = tx_w[k];
    return ord ? w[b] : w[7-b];
  endfunction

  task automatic set_idle();
    exp_busy = 0; exp_ss = 4'hF; exp_sclk = cpol_i; exp_mosi = 0; exp_ready = 0;
  endtask

  // Advance one clock; pulse-type inputs are cleared for the next cycle.
  task automatic cyc();
    logic a;
    if (rel == extra_start) start_i = 1'b1;
    if (rel == abort_rel) begin rst_i = 1'b1; aborted = 1; end
    a = ack_i;
    @(posedge clk);
    #1;
    rel++;
    if (!aborted) begin
      if (irq_set) exp_irq = 1'b1;
      else if (a)  exp_irq = 1'b0;
    end
    irq_set = 0;
    start_i = 0; ack_i = 0; rst_i = 0; tx_valid_i = 0; exp_rxv = 0;
  endtask

  task automatic idle(input int n, input bit ack);
    abort_rel = -1; extra_start = -1;
    for (int i = 0; i < n; i++) begin
      set_idle();
      if (ack && i == 0) ack_i = 1'b1;
      cyc();
    end
  endtask

  // One burst as a timeline: SS setup T, per word a LOAD (plus stall) and
  // 2*8*T bit cycles, then T of SS hold; irq visible on the following cycle.
  task automatic run_burst(input bit pol, input bit pha, input bit ord, input int dv,
                           input int ln, input int sl, input int abort_at,
                           input int xstart, input bit ack_set);
    int t;
    logic [3:0] ssm;
    t = dv + 1;
    ssm = (sl < 4) ? ~(4'b0001 << sl) : 4'hF;
    rel = 0; abort_rel = abort_at; extra_start = xstart; aborted = 0;
    cpol_i = pol; cpha_i = pha; dord_i = ord; div_i = 8'(dv); len_i = 8'(ln);
    ss_sel_i = 3'(sl); start_i = 1'b1;
    set_idle();
    cyc(); if (aborted) return;
    // scramble configuration to show it was latched at start
    cpol_i = ~pol; cpha_i = ~pha; dord_i = ~ord; div_i = 8'(dv + 3); len_i = '0; ss_sel_i = '0;
    for (int i = 0; i < t; i++) begin
      exp_busy = 1; exp_ss = ssm; exp_sclk = pol; exp_ready = 0;
      cyc(); if (aborted) return;
    end
    for (int k = 0; k <= ln; k++) begin
      for (int i = 0; i <= stall_w[k]; i++) begin
        exp_busy = 1; exp_ss = ssm; exp_sclk = pol; exp_ready = 1;
        if (i == stall_w[k]) begin tx_valid_i = 1'b1; tx_data_i = tx_w[k]; end
        else tx_data_i = ~tx_w[k];
        cyc(); if (aborted) return;
      end
      for (int c = 1; c <= 16 * t; c++) begin
        int b;
        b = (c - 1) / (2 * t);
        exp_ready = 0;
        exp_sclk = pol ^ (((c - 1) / t) % 2 == 1);
        miso_i = ord ? rx_w[k][b] : rx_w[k][7-b];
        if (!pha)       exp_mosi = txbit(k, b, ord);
        else if (c > t) exp_mosi = txbit(k, (c - 1 - t) / (2 * t), ord);
        cyc(); if (aborted) return;
      end
      exp_rxv = 1; exp_rxd = rx_w[k];
    end
    for (int i = 0; i < t; i++) begin
      exp_busy = 1; exp_ss = ssm; exp_sclk = pol; exp_ready = 0;
      if (i == t - 1) begin irq_set = 1; if (ack_set) ack_i = 1'b1; end
      cyc(); if (aborted) return;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) stall_w[i] = 0;
    clr_mon();
    exp_rxv = 0; exp_irq = 0; exp_rxd = '0;
    repeat (3) @(posedge clk);
    #1;
    set_idle();
    chk_en = 1'b1;
    chk("reset_ss", ss_n_o, 4'hF);
    chk("reset_busy", busy_o, 0);
    chk("reset_rx_data", rx_data_o, 0);
    cyc();
    idle(2, 0);

    // mode 0, div 1, single word to slave 2
    tx_w[0] = 8'hA5; rx_w[0] = 8'h3C;
    clr_mon();
    run_burst(0, 0, 0, 1, 0, 2, -1, -1, 0);
    idle(1, 0);
    chk("t1_irq_cycle", irq_rise_rel, 38);
    chk("t1_mosi_seq", cap, 8'hA5);
    chk("t1_edges", edges, 8);
    chk("t1_ss", ss_and, 4'b1011);
    chk("t1_rx", rx_data_o, 8'h3C);
    chk("t1_rxv_cnt", rxv_cnt, 1);
    idle(2, 1);

    // mode 3, LSB first, div 2
    tx_w[0] = 8'h01; rx_w[0] = 8'h80;
    clr_mon();
    run_burst(1, 1, 1, 2, 0, 0, -1, -1, 0);
    idle(1, 0);
    chk("t2_mosi_seq", cap, 8'h80);
    chk("t2_edges", edges, 8);
    chk("t2_rx", rx_data_o, 8'h80);
    idle(2, 1);

    // 3-word burst, mode 1, div 0, 20-cycle underrun before word 2
    tx_w[0] = 8'h5A; tx_w[1] = 8'hC3; tx_w[2] = 8'h7E;
    rx_w[0] = 8'h12; rx_w[1] = 8'h34; rx_w[2] = 8'hFF;
    stall_w[1] = 20;
    clr_mon();
    run_burst(0, 1, 0, 0, 2, 1, -1, -1, 0);
    idle(1, 0);
    stall_w[1] = 0;
    chk("t3_rxv_cnt", rxv_cnt, 3);
    chk("t3_irq_rises", irq_rises, 1);
    chk("t3_irq_cycle", irq_rise_rel, 74);
    chk("t3_edges", edges, 24);
    idle(2, 1);

    // mode 2, div 3, 2 words, start while busy, ack coincides with irq set
    tx_w[0] = 8'h96; tx_w[1] = 8'h3C; rx_w[0] = 8'hE1; rx_w[1] = 8'h0F;
    clr_mon();
    run_burst(1, 0, 0, 3, 1, 3, -1, 10, 1);
    set_idle();
    chk("t4_set_wins", irq_o, 1);
    ack_i = 1'b1;
    cyc();
    set_idle();
    chk("t4_ack_clears", irq_o, 0);
    cyc();
    chk("t4_irq_rises", irq_rises, 1);
    chk("t4_rxv_cnt", rxv_cnt, 2);
    idle(2, 0);

    // reset mid word 2 of 3, then a fresh transfer
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
    rx_w[0] = 8'hAB; rx_w[1] = 8'hCD; rx_w[2] = 8'hEF;
    clr_mon();
    run_burst(0, 0, 0, 1, 2, 0, 46, -1, 0);
    set_idle(); exp_irq = 0; exp_rxd = '0; exp_rxv = 0;
    chk("t5_aborted", aborted, 1);
    chk("t5_ss", ss_n_o, 4'hF);
    chk("t5_busy", busy_o, 0);
    chk("t5_rx_data", rx_data_o, 0);
    cyc();
    idle(2, 0);
    chk("t5_rxv_cnt", rxv_cnt, 1);
    tx_w[0] = 8'hC9; rx_w[0] = 8'h6B;
    clr_mon();
    run_burst(0, 0, 0, 0, 0, 1, -1, -1, 0);
    idle(1, 0);
    chk("t5b_rx", rx_data_o, 8'h6B);
    chk("t5b_edges", edges, 8);
    idle(2, 1);

    // out-of-range select
    tx_w[0] = 8'h0F; rx_w[0] = 8'hF0;
    clr_mon();
    run_burst(0, 1, 0, 1, 0, 5, -1, -1, 0);
    idle(1, 0);
    chk("t6_ss", ss_and, 4'hF);
    chk("t6_irq_rises", irq_rises, 1);
    chk("t6_rx", rx_data_o, 8'hF0);
    idle(2, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
